// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: timestamped WB-stage register-write capture into a circular buffer, drained first-word-fall-through
module wb_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int CYC_W  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              wrap_mode,
    input  logic [31:0]       reg_mask,
    input  logic              wb_valid,
    input  logic [4:0]        wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [CYC_W-1:0]  rd_cycle,
    output logic [4:0]        rd_reg,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [15:0]       dropped,
    output logic [CYC_W-1:0]  cycle_count
);
    localparam int ENT_W = CYC_W + 5 + DATA_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr, rdPtr;
    logic              capture, pop, full, accept, lost, overwrite, doWrite;

    assign capture   = enable && wb_valid && wb_reg != 5'd0 && reg_mask[wb_reg];
    assign rd_valid  = count != '0;
    assign pop       = rd_valid && rd_ready;
    assign full      = count == FULL_CNT;
    // A pop frees the slot this cycle, so a full buffer with a pop still accepts normally
    assign accept    = capture && (!full || pop);
    assign lost      = capture && full && !pop;
    assign overwrite = lost && wrap_mode;
    assign doWrite   = accept || overwrite;
    assign {rd_cycle, rd_reg, rd_data} = mem[rdPtr];

    always_ff @(posedge clk)
        if (doWrite && !clear) mem[wrPtr] <= {cycle_count, wb_reg, wb_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            dropped     <= '0;
            cycle_count <= '0;
        end else if (clear) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            dropped     <= '0;
            cycle_count <= '0;
        end else begin
            if (enable) cycle_count <= cycle_count + CYC_W'(1);
            if (doWrite) wrPtr <= wrPtr + ADDR_W'(1);
            if (pop || overwrite) rdPtr <= rdPtr + ADDR_W'(1);
            count <= count + (ADDR_W+1)'(accept) - (ADDR_W+1)'(pop);
            if (lost) begin
                overflow <= 1'b1;
                dropped  <= dropped == 16'hFFFF ? dropped : dropped + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed test-plan scenarios plus random traffic against a queue-based model
module tb_wb_trace_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset, enable, clear, wrapMode, wbValid, rdReady;
    logic [31:0] regMask, wbData, rdData;
    logic [4:0]  wbReg, rdReg;
    logic        rdValid, overflow;
    logic [15:0] rdCycle, dropped, cycleCount;
    logic [4:0]  count;

    logic [52:0] mq[$];
    logic [15:0] mCyc, mDrop;
    logic        mOvf;
    int          nChecks = 0, nErrors = 0;

    always #5 clk = ~clk;

    wb_trace_buffer dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .wrap_mode(wrapMode),
        .reg_mask(regMask), .wb_valid(wbValid), .wb_reg(wbReg), .wb_data(wbData),
        .rd_ready(rdReady), .rd_valid(rdValid), .rd_cycle(rdCycle), .rd_reg(rdReg),
        .rd_data(rdData), .count(count), .overflow(overflow), .dropped(dropped),
        .cycle_count(cycleCount)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mCyc  = '0;
        mDrop = '0;
        mOvf  = 1'b0;
    endtask

    task automatic modelStep();
        logic cap, pop, wasFull;
        if (clear) begin
            modelReset();
            return;
        end
        cap     = enable && wbValid && wbReg != 0 && regMask[wbReg];
        wasFull = mq.size() == DEPTH;
        pop     = mq.size() != 0 && rdReady;
        if (pop) void'(mq.pop_front());
        if (cap) begin
            if (wasFull && !pop) begin
                mOvf = 1'b1;
                if (mDrop != 16'hFFFF) mDrop++;
                if (wrapMode) begin
                    void'(mq.pop_front());
                    mq.push_back({mCyc, wbReg, wbData});
                end
            end else mq.push_back({mCyc, wbReg, wbData});
        end
        if (enable) mCyc++;
    endtask

    task automatic checkAll();
        check("count", 64'(count), 64'(mq.size()));
        check("rd_valid", 64'(rdValid), 64'(mq.size() != 0));
        check("overflow", 64'(overflow), 64'(mOvf));
        check("dropped", 64'(dropped), 64'(mDrop));
        check("cycle_count", 64'(cycleCount), 64'(mCyc));
        if (mq.size() != 0) check("head", 64'({rdCycle, rdReg, rdData}), 64'(mq[0]));
    endtask

    task automatic cyc();
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic setIn(input logic v, input logic [4:0] r, input logic [31:0] d, input logic rdy);
        wbValid = v;
        wbReg   = r;
        wbData  = d;
        rdReady = rdy;
    endtask

    task automatic fill(input int n, input logic rdy);
        for (int i = 1; i <= n; i++) begin
            setIn(1'b1, 5'($urandom_range(1, 31)), 32'(i), rdy);
            cyc();
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            setIn(1'b0, 5'd0, 32'd0, rdy);
            cyc();
        end
    endtask

    task automatic doClear();
        clear = 1'b1;
        idle(1, 1'b0);
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; clear = 1'b0; wrapMode = 1'b0; regMask = '1;
        setIn(1'b0, 5'd0, 32'd0, 1'b0);
        modelReset();
        #1;
        check("reset_count", 64'(count), 64'd0);
        check("reset_valid", 64'(rdValid), 64'd0);
        check("reset_cycle", 64'(cycleCount), 64'd0);
        #11 reset = 1'b1;

        // Two writes at cycles 3 and 4, drained immediately
        idle(3, 1'b1);
        setIn(1'b1, 5'd16, 32'h5, 1'b1); cyc();
        check("t1_head_cycle", 64'(rdCycle), 64'd3);
        check("t1_head_reg", 64'(rdReg), 64'd16);
        check("t1_head_data", 64'(rdData), 64'h5);
        setIn(1'b1, 5'd8, 32'hA, 1'b1); cyc();
        check("t1_second", 64'({rdCycle, rdReg, rdData}), 64'({16'd4, 5'd8, 32'hA}));
        idle(1, 1'b1);
        check("t1_empty", 64'(count), 64'd0);

        // $zero never captured, mask filters $9
        setIn(1'b1, 5'd0, 32'h77, 1'b0); cyc();
        regMask = 32'h0000_0100;
        setIn(1'b1, 5'd8, 32'h88, 1'b0); cyc();
        setIn(1'b1, 5'd9, 32'h99, 1'b0); cyc();
        check("t2_count", 64'(count), 64'd1);
        check("t2_reg", 64'(rdReg), 64'd8);
        regMask = '1;
        idle(2, 1'b1);

        // Stop-when-full drops the last four
        fill(20, 1'b0);
        check("t3_count", 64'(count), 64'd16);
        check("t3_dropped", 64'(dropped), 64'd4);
        check("t3_head", 64'(rdData), 64'd1);
        idle(16, 1'b1);
        doClear();

        // Wrap mode keeps the newest sixteen
        wrapMode = 1'b1;
        fill(20, 1'b0);
        check("t4_count", 64'(count), 64'd16);
        check("t4_dropped", 64'(dropped), 64'd4);
        check("t4_head", 64'(rdData), 64'd5);
        idle(16, 1'b1);
        doClear();

        // Full buffer with capture and pop together is not a drop
        wrapMode = 1'b0;
        fill(16, 1'b0);
        setIn(1'b1, 5'd3, 32'hCAFE, 1'b1); cyc();
        check("t5_count", 64'(count), 64'd16);
        check("t5_overflow", 64'(overflow), 64'd0);
        check("t5_head", 64'(rdData), 64'd2);
        idle(15, 1'b1);
        check("t5_last", 64'(rdData), 64'hCAFE);
        idle(1, 1'b1);
        doClear();

        // Asynchronous reset between edges mid-fill
        fill(7, 1'b0);
        #3 reset = 1'b0;
        #1;
        check("t6_count", 64'(count), 64'd0);
        check("t6_valid", 64'(rdValid), 64'd0);
        check("t6_cycle", 64'(cycleCount), 64'd0);
        modelReset();
        reset = 1'b1;
        setIn(1'b1, 5'd12, 32'h1234, 1'b0); cyc();
        check("t6_first_ts", 64'(rdCycle), 64'd0);
        clear = 1'b1;
        setIn(1'b1, 5'd13, 32'h4321, 1'b1); cyc();
        clear = 1'b0;
        check("t6_clear", 64'(count), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            enable = $urandom_range(0, 9) != 0;
            clear  = $urandom_range(0, 59) == 0;
            if ($urandom_range(0, 99) == 0) wrapMode = ~wrapMode;
            if ($urandom_range(0, 199) == 0) regMask = $urandom_range(0, 2) == 0 ? $urandom : '1;
            setIn($urandom_range(0, 9) < 6, 5'($urandom), $urandom, $urandom_range(0, 9) < 4);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Parametrised register-writeback trace buffer for the pipelined MIPS core.
- Taps the WB-stage register write (RegWriteWB, WriteRegister, WriteData) and timestamps each qualifying write with a free-running cycle counter.
- Stores entries in a DEPTH-entry circular buffer; a valid/ready port drains them, replacing per-cycle register dumps in simulation and enabling on-chip capture.
- Adds register filtering, stop-or-wrap full policy, overflow/drop accounting and synchronous clear.

Parameters:
- DATA_W, 32, width of captured write data.
- CYC_W, 16, width of cycle timestamp; counter wraps modulo 2^CYC_W.
- DEPTH, 16, number of entries; must be a power of two, >= 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = cycle counter runs and capture allowed.
- clear  in  1  synchronous clear of buffer, counters and flags.
- wrap_mode  in  1  0 = stop/drop when full; 1 = overwrite oldest.
- reg_mask  in  32  bit i set = writes to register i are captured.
- wb_valid  in  1  WB-stage RegWrite.
- wb_reg  in  5  WB destination register.
- wb_data  in  DATA_W  WB write data.
- rd_ready  in  1  consumer accepts head entry.
- rd_valid  out  1  buffer non-empty.
- rd_cycle  out  CYC_W  head entry timestamp.
- rd_reg  out  5  head entry register number.
- rd_data  out  DATA_W  head entry data.
- count  out  ADDR_W+1  entries held, 0..DEPTH.
- overflow  out  1  sticky; set on any drop or overwrite.
- dropped  out  16  saturating count of lost entries, both modes.
- cycle_count  out  CYC_W  current cycle counter.

Behaviour:
- Reset (reset=0, async): pointers, count, overflow, dropped and cycle_count go to 0. rd_valid=0. rd_* outputs are don't-care while rd_valid=0.
- cycle_count increments every clk while enable=1 and wraps at 2^CYC_W-1 -> 0. It holds while enable=0.
- Capture condition:
  - enable && wb_valid && wb_reg!=0 && reg_mask[wb_reg].
  - Writes to $zero are never captured.
- Entry format: {cycle_count pre-increment value of the capture cycle, wb_reg, wb_data}.
- Latency: an entry captured at edge N is visible on rd_* after edge N when it is the head. There is no same-cycle bypass: if empty, rd_valid rises one cycle after capture.
- Read side:
  - First-word-fall-through: rd_* show the head entry combinationally from storage.
  - Pop occurs when rd_valid && rd_ready, advancing the read pointer.
  - rd_ready while empty has no effect.
- Pointers wrap modulo DEPTH. count is tracked explicitly so full (count==DEPTH) is distinguished from empty.
- Capture with pop in the same cycle: both are performed and count is unchanged. This holds even when full, where the capture is not treated as a full-event (no drop, no overflow).
- Full, capture, no pop, wrap_mode=0: entry discarded, overflow<=1, dropped increments. Buffer contents are unchanged.
- Full, capture, no pop, wrap_mode=1: oldest entry overwritten. Read and write pointers both advance, count stays DEPTH, overflow<=1, dropped increments.
- dropped saturates at 16'hFFFF.
- Changing wrap_mode mid-run takes effect on the next capture. Stored data is unaffected.
- clear=1 (synchronous, highest priority after reset):
  - pointers, count, overflow, dropped and cycle_count go to 0;
  - a capture and a pop in the same cycle are ignored.
- enable=0 blocks capture but not readout. Draining is allowed while frozen.

Test Plan:
- Reset then enable=1, reg_mask=FFFFFFFF; WB writes $16=00000005 at cycle 3 and $8=0000000A at cycle 4, rd_ready=1 -> rd_valid pulses, reading {3,16,00000005} then {4,8,0000000A}; count returns to 0.
- wb_reg=0 with wb_valid=1, and reg_mask=00000100 with writes to $8 and $9 -> only the $8 entry is captured; count=1.
- wrap_mode=0, rd_ready=0, 20 captures with data 1..20 -> count=16, overflow=1, dropped=4; draining yields data 1..16 in order.
- wrap_mode=1, same 20 captures -> count=16, overflow=1, dropped=4; draining yields data 5..20.
- Full buffer, capture and rd_ready=1 in the same cycle -> count stays 16, overflow stays 0, head advances by one, new entry is last.
- Assert reset low mid-fill (count=7) asynchronously between edges -> count, rd_valid and cycle_count are 0 immediately; after release, the first capture has timestamp 0. Also check clear=1 coincident with a capture -> count=0 next cycle.
